// File: rtl/seq_detect_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_ctrl_if
// Description : Command, serial-bit and status bundle for seq_detect_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
interface seq_detect_ctrl_if #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 4
);
    logic             start;
    logic [3:0]       pattern;
    logic [LEN_W-1:0] frame_len;
    logic             bit_valid;
    logic             bit_in;
    logic             busy;
    logic             match;
    logic [CNT_W-1:0] match_count;
    logic             done;

    modport master (
        output start, pattern, frame_len, bit_valid, bit_in,
        input  busy, match, match_count, done
    );

    modport slave (
        input  start, pattern, frame_len, bit_valid, bit_in,
        output busy, match, match_count, done
    );
endinterface
`default_nettype wire

// File: rtl/seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seq_detect_ctrl
// Description : Framed programmable 4-bit serial pattern detector with Moore
//               match pulse, saturating match count and end-of-frame pulse.
//               Define SEQ_CTRL_OVERLAP_EN for overlapping detection.
// Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_ctrl #(
    parameter int LEN_W = 8,
    parameter int CNT_W = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    seq_detect_ctrl_if.slave  bus
);
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [2:0]       c_FULL    = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_pat;
    logic [3:0]       r_hist;
    logic [2:0]       r_fill;
    logic [LEN_W-1:0] r_rem;
    logic             r_match;
    logic [CNT_W-1:0] r_count;

    logic [3:0]       w_hist_n;
    logic [2:0]       w_fill_n;
    logic             w_hit;

    always_comb begin
        w_hist_n = {r_hist[2:0], bus.bit_in};
        w_fill_n = (r_fill == c_FULL) ? c_FULL : r_fill + 3'd1;
        w_hit    = (w_fill_n == c_FULL) && (w_hist_n == r_pat);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_pat   <= '0;
            r_hist  <= '0;
            r_fill  <= '0;
            r_rem   <= '0;
            r_match <= 1'b0;
            r_count <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_match <= 1'b0;
                    if (bus.start) begin
                        r_pat   <= bus.pattern;
                        r_rem   <= bus.frame_len;
                        r_hist  <= '0;
                        r_fill  <= '0;
                        r_count <= '0;
                        r_state <= (bus.frame_len == '0) ? S_DONE : S_RUN;
                    end
                end
                S_RUN: begin
                    if (bus.bit_valid) begin
                        r_hist  <= w_hist_n;
                        r_fill  <= w_fill_n;
                        r_rem   <= r_rem - LEN_W'(1);
                        r_match <= w_hit;
                        if (w_hit && (r_count != c_CNT_MAX)) begin
                            r_count <= r_count + CNT_W'(1);
                        end
`ifndef SEQ_CTRL_OVERLAP_EN
                        // Non-overlapping: a hit consumes its four bits.
                        if (w_hit) begin
                            r_hist <= '0;
                            r_fill <= '0;
                        end
`endif
                        if (r_rem == LEN_W'(1)) begin
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_match <= 1'b0;
                    end
                end
                S_DONE: begin
                    r_match <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_match <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = (r_state != S_IDLE);
    assign bus.done        = (r_state == S_DONE);
    assign bus.match       = r_match;
    assign bus.match_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seq_detect_ctrl
// Description : Directed self-checking bench for seq_detect_ctrl (both builds).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_ctrl;
    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    seq_detect_ctrl_if #(.LEN_W(8), .CNT_W(4)) u_bus  ();
    seq_detect_ctrl_if #(.LEN_W(8), .CNT_W(2)) u_bus2 ();

    seq_detect_ctrl #(.LEN_W(8), .CNT_W(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_bus.slave)
    );

    seq_detect_ctrl #(.LEN_W(8), .CNT_W(2)) u_dut2 (
        .clk (clk),
        .rst (rst),
        .bus (u_bus2.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        n_total++; if (u_bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", u_bus.busy); else n_pass++;
        n_total++; if (u_bus.match !== 1'b0) $display("FAIL reset_match: got %b expected 0", u_bus.match); else n_pass++;
        n_total++; if (u_bus.done !== 1'b0) $display("FAIL reset_done: got %b expected 0", u_bus.done); else n_pass++;
        n_total++; if (u_bus.match_count !== 4'd0) $display("FAIL reset_count: got %0d expected 0", u_bus.match_count); else n_pass++;
        n_total++; if (u_bus2.match_count !== 2'd0) $display("FAIL reset_count2: got %0d expected 0", u_bus2.match_count); else n_pass++;
    endtask

    task automatic test_pattern_1010();
        logic [7:0] bits;
        logic [7:0] exp_m;
        bits = 8'b1010_1010;
`ifdef SEQ_CTRL_OVERLAP_EN
        exp_m = 8'b1010_1000;   // hits after bits 4, 6, 8
`else
        exp_m = 8'b1000_1000;   // hits after bits 4, 8
`endif
        u_bus.pattern   = 4'b1010;
        u_bus.frame_len = 8'd8;
        u_bus.start     = 1'b1;
        tick();
        u_bus.start = 1'b0;
        n_total++; if (u_bus.busy !== 1'b1) $display("FAIL p1010_busy: got %b expected 1", u_bus.busy); else n_pass++;
        for (int i = 0; i < 8; i++) begin
            u_bus.bit_valid = 1'b1;
            u_bus.bit_in    = bits[7-i];
            tick();
            n_total++; if (u_bus.match !== exp_m[i]) $display("FAIL p1010_match bit %0d: got %b expected %b", i + 1, u_bus.match, exp_m[i]); else n_pass++;
            n_total++; if (u_bus.done !== (i == 7)) $display("FAIL p1010_done bit %0d: got %b expected %b", i + 1, u_bus.done, (i == 7)); else n_pass++;
        end
        u_bus.bit_valid = 1'b0;
`ifdef SEQ_CTRL_OVERLAP_EN
        n_total++; if (u_bus.match_count !== 4'd3) $display("FAIL p1010_count: got %0d expected 3", u_bus.match_count); else n_pass++;
`else
        n_total++; if (u_bus.match_count !== 4'd2) $display("FAIL p1010_count: got %0d expected 2", u_bus.match_count); else n_pass++;
`endif
        tick();
        n_total++; if (u_bus.busy !== 1'b0) $display("FAIL p1010_idle_busy: got %b expected 0", u_bus.busy); else n_pass++;
        n_total++; if (u_bus.match !== 1'b0) $display("FAIL p1010_idle_match: got %b expected 0", u_bus.match); else n_pass++;
    endtask

    task automatic test_zero_len();
        u_bus.pattern   = 4'b0000;
        u_bus.frame_len = 8'd0;
        u_bus.start     = 1'b1;
        tick();
        u_bus.start = 1'b0;
        n_total++; if (u_bus.done !== 1'b1) $display("FAIL zlen_done: got %b expected 1", u_bus.done); else n_pass++;
        n_total++; if (u_bus.busy !== 1'b1) $display("FAIL zlen_busy: got %b expected 1", u_bus.busy); else n_pass++;
        n_total++; if (u_bus.match_count !== 4'd0) $display("FAIL zlen_count: got %0d expected 0", u_bus.match_count); else n_pass++;
        n_total++; if (u_bus.match !== 1'b0) $display("FAIL zlen_match: got %b expected 0", u_bus.match); else n_pass++;
        tick();
        n_total++; if (u_bus.busy !== 1'b0) $display("FAIL zlen_busy_end: got %b expected 0", u_bus.busy); else n_pass++;
        n_total++; if (u_bus.done !== 1'b0) $display("FAIL zlen_done_end: got %b expected 0", u_bus.done); else n_pass++;
        n_total++; if (u_bus.match !== 1'b0) $display("FAIL zlen_match_end: got %b expected 0", u_bus.match); else n_pass++;
    endtask

    task automatic test_saturation();
        int hits;
        hits = 0;
        u_bus2.pattern   = 4'b1111;
        u_bus2.frame_len = 8'd10;
        u_bus2.start     = 1'b1;
        tick();
        u_bus2.start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            u_bus2.bit_valid = 1'b1;
            u_bus2.bit_in    = 1'b1;
            tick();
            if (u_bus2.match === 1'b1) hits++;
        end
        u_bus2.bit_valid = 1'b0;
        n_total++; if (u_bus2.done !== 1'b1) $display("FAIL sat_done: got %b expected 1", u_bus2.done); else n_pass++;
`ifdef SEQ_CTRL_OVERLAP_EN
        n_total++; if (hits !== 7) $display("FAIL sat_hits: got %0d expected 7", hits); else n_pass++;
        n_total++; if (u_bus2.match_count !== 2'd3) $display("FAIL sat_count: got %0d expected 3", u_bus2.match_count); else n_pass++;
`else
        n_total++; if (hits !== 2) $display("FAIL sat_hits: got %0d expected 2", hits); else n_pass++;
        n_total++; if (u_bus2.match_count !== 2'd2) $display("FAIL sat_count: got %0d expected 2", u_bus2.match_count); else n_pass++;
`endif
        tick();
        n_total++; if (u_bus2.busy !== 1'b0) $display("FAIL sat_idle: got %b expected 0", u_bus2.busy); else n_pass++;
    endtask

    task automatic test_gaps();
        logic [3:0] bits;
        int         hits;
        bits = 4'b0110;
        hits = 0;
        u_bus.pattern   = 4'b0110;
        u_bus.frame_len = 8'd4;
        u_bus.start     = 1'b1;
        tick();
        u_bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            u_bus.bit_valid = 1'b1;
            u_bus.bit_in    = bits[3-i];
            tick();
            u_bus.bit_valid = 1'b0;
            u_bus.bit_in    = 1'b1;
            if (u_bus.match === 1'b1) hits++;
            n_total++; if (u_bus.match !== (i == 3)) $display("FAIL gap_match bit %0d: got %b expected %b", i + 1, u_bus.match, (i == 3)); else n_pass++;
            n_total++; if (u_bus.done !== (i == 3)) $display("FAIL gap_done bit %0d: got %b expected %b", i + 1, u_bus.done, (i == 3)); else n_pass++;
            if (i < 3) begin
                for (int g = 0; g < 3; g++) begin
                    tick();
                    if (u_bus.match === 1'b1) hits++;
                    n_total++; if (u_bus.done !== 1'b0) $display("FAIL gap_done_idle: got %b expected 0", u_bus.done); else n_pass++;
                end
            end
        end
        n_total++; if (hits !== 1) $display("FAIL gap_hits: got %0d expected 1", hits); else n_pass++;
        n_total++; if (u_bus.match_count !== 4'd1) $display("FAIL gap_count: got %0d expected 1", u_bus.match_count); else n_pass++;
        tick();
    endtask

    task automatic test_ignored_start();
        logic [3:0] bits;
        bits = 4'b1100;
        u_bus.pattern   = 4'b1100;
        u_bus.frame_len = 8'd4;
        u_bus.start     = 1'b1;
        tick();
        // Hold start with different settings through RUN and DONE.
        u_bus.pattern   = 4'b0000;
        u_bus.frame_len = 8'd2;
        for (int i = 0; i < 4; i++) begin
            u_bus.bit_valid = 1'b1;
            u_bus.bit_in    = bits[3-i];
            tick();
            n_total++; if (u_bus.done !== (i == 3)) $display("FAIL ign_done bit %0d: got %b expected %b", i + 1, u_bus.done, (i == 3)); else n_pass++;
        end
        u_bus.bit_valid = 1'b0;
        n_total++; if (u_bus.match !== 1'b1) $display("FAIL ign_match: got %b expected 1", u_bus.match); else n_pass++;
        n_total++; if (u_bus.match_count !== 4'd1) $display("FAIL ign_count: got %0d expected 1", u_bus.match_count); else n_pass++;
        tick();
        n_total++; if (u_bus.busy !== 1'b0) $display("FAIL ign_idle: got %b expected 0", u_bus.busy); else n_pass++;
        tick();
        u_bus.start = 1'b0;
        n_total++; if (u_bus.busy !== 1'b1) $display("FAIL ign_accept: got %b expected 1", u_bus.busy); else n_pass++;
        n_total++; if (u_bus.match_count !== 4'd0) $display("FAIL ign_accept_count: got %0d expected 0", u_bus.match_count); else n_pass++;
        for (int i = 0; i < 2; i++) begin
            u_bus.bit_valid = 1'b1;
            u_bus.bit_in    = 1'b0;
            tick();
            n_total++; if (u_bus.done !== (i == 1)) $display("FAIL ign_len2_done bit %0d: got %b expected %b", i + 1, u_bus.done, (i == 1)); else n_pass++;
        end
        u_bus.bit_valid = 1'b0;
        n_total++; if (u_bus.match_count !== 4'd0) $display("FAIL ign_len2_count: got %0d expected 0", u_bus.match_count); else n_pass++;
        tick();
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] bits;
        bits = 8'b1010_1010;
        u_bus.pattern   = 4'b1010;
        u_bus.frame_len = 8'd8;
        u_bus.start     = 1'b1;
        tick();
        u_bus.start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            u_bus.bit_valid = 1'b1;
            u_bus.bit_in    = bits[7-i];
            tick();
        end
        n_total++; if (u_bus.match_count !== 4'd1) $display("FAIL rmid_precount: got %0d expected 1", u_bus.match_count); else n_pass++;
        u_bus.bit_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_total++; if (u_bus.busy !== 1'b0) $display("FAIL rmid_busy: got %b expected 0", u_bus.busy); else n_pass++;
        n_total++; if (u_bus.match !== 1'b0) $display("FAIL rmid_match: got %b expected 0", u_bus.match); else n_pass++;
        n_total++; if (u_bus.done !== 1'b0) $display("FAIL rmid_done: got %b expected 0", u_bus.done); else n_pass++;
        n_total++; if (u_bus.match_count !== 4'd0) $display("FAIL rmid_count: got %0d expected 0", u_bus.match_count); else n_pass++;
        tick();
        n_total++; if (u_bus.done !== 1'b0) $display("FAIL rmid_nodone: got %b expected 0", u_bus.done); else n_pass++;
        u_bus.pattern   = 4'b1010;
        u_bus.frame_len = 8'd4;
        u_bus.start     = 1'b1;
        tick();
        u_bus.start = 1'b0;
        n_total++; if (u_bus.match_count !== 4'd0) $display("FAIL rmid_new_count0: got %0d expected 0", u_bus.match_count); else n_pass++;
        for (int i = 0; i < 4; i++) begin
            u_bus.bit_valid = 1'b1;
            u_bus.bit_in    = bits[7-i];
            tick();
        end
        u_bus.bit_valid = 1'b0;
        n_total++; if (u_bus.match !== 1'b1) $display("FAIL rmid_new_match: got %b expected 1", u_bus.match); else n_pass++;
        n_total++; if (u_bus.done !== 1'b1) $display("FAIL rmid_new_done: got %b expected 1", u_bus.done); else n_pass++;
        n_total++; if (u_bus.match_count !== 4'd1) $display("FAIL rmid_new_count: got %0d expected 1", u_bus.match_count); else n_pass++;
        tick();
        n_total++; if (u_bus.match_count !== 4'd1) $display("FAIL rmid_hold_count: got %0d expected 1", u_bus.match_count); else n_pass++;
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst     = 1'b1;
        u_bus.start      = 1'b0;
        u_bus.pattern    = 4'b0000;
        u_bus.frame_len  = 8'd0;
        u_bus.bit_valid  = 1'b0;
        u_bus.bit_in     = 1'b0;
        u_bus2.start     = 1'b0;
        u_bus2.pattern   = 4'b0000;
        u_bus2.frame_len = 8'd0;
        u_bus2.bit_valid = 1'b0;
        u_bus2.bit_in    = 1'b0;

        test_reset();
        test_pattern_1010();
        test_zero_len();
        test_saturation();
        test_gaps();
        test_ignored_start();
        test_reset_mid_frame();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
